// File: rtl/conv2_scheduler.sv
// Address/control sequencer for a single-MAC 2D valid convolution.
// Walks output windows and kernel taps; drives MAC and write-back.
module conv2_scheduler #(
    parameter int SIZE    = 32,
    parameter int SIZEKer = 3,
    parameter int STRIDE  = 1,
    parameter int AW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] img_row,
    output logic [AW-1:0] img_col,
    output logic [AW-1:0] ker_row,
    output logic [AW-1:0] ker_col,
    output logic          rd_valid,
    output logic          mac_clear,
    output logic          mac_en,
    output logic          out_we,
    output logic [AW-1:0] out_row,
    output logic [AW-1:0] out_col
);

    localparam int NOUT = (SIZE - SIZEKer) / STRIDE + 1;
    localparam logic [AW-1:0] KLAST = AW'(SIZEKer - 1);
    localparam logic [AW-1:0] OLAST = AW'(NOUT - 1);
    localparam logic [AW:0] STR = (AW + 1)'(STRIDE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] out_r_q, out_r_d;
    logic [AW-1:0] out_c_q, out_c_d;
    logic [AW-1:0] ki_q, ki_d;
    logic [AW-1:0] kj_q, kj_d;

    logic          mac_en_q, mac_en_d;
    logic          mac_clear_q, mac_clear_d;
    logic          wlast_q, wlast_d;
    logic          fin1_q, fin1_d;
    logic [AW-1:0] row1_q, row1_d;
    logic [AW-1:0] col1_q, col1_d;
    logic          out_we_q, out_we_d;
    logic          fin2_q, fin2_d;
    logic [AW-1:0] out_row_q, out_row_d;
    logic [AW-1:0] out_col_q, out_col_d;

    logic issue;
    logic kj_last, ki_last, c_last, r_last;
    logic win_last, final_tap;

    always_comb begin
        issue     = (state_q == S_RUN) && !stall;
        kj_last   = (kj_q == KLAST);
        ki_last   = (ki_q == KLAST);
        c_last    = (out_c_q == OLAST);
        r_last    = (out_r_q == OLAST);
        win_last  = issue && ki_last && kj_last;
        final_tap = win_last && c_last && r_last;
    end

    always_comb begin
        state_d = state_q;
        out_r_d = out_r_q;
        out_c_d = out_c_q;
        ki_d    = ki_q;
        kj_d    = kj_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    out_r_d = '0;
                    out_c_d = '0;
                    ki_d    = '0;
                    kj_d    = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    // kj is the fastest-moving index, out_r the slowest
                    kj_d = kj_last ? '0 : kj_q + 1'b1;
                    if (kj_last) begin
                        ki_d = ki_last ? '0 : ki_q + 1'b1;
                        if (ki_last) begin
                            out_c_d = c_last ? '0 : out_c_q + 1'b1;
                            if (c_last) begin
                                out_r_d = r_last ? '0 : out_r_q + 1'b1;
                            end
                        end
                    end
                    if (final_tap) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_we_q && fin2_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mac_en_d    = issue;
        mac_clear_d = issue && (ki_q == '0) && (kj_q == '0);
        wlast_d     = win_last;
        fin1_d      = final_tap;
        row1_d      = win_last ? out_r_q : row1_q;
        col1_d      = win_last ? out_c_q : col1_q;
        out_we_d    = wlast_q;
        fin2_d      = fin1_q;
        out_row_d   = wlast_q ? row1_q : out_row_q;
        out_col_d   = wlast_q ? col1_q : out_col_q;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= S_IDLE;
            out_r_q     <= '0;
            out_c_q     <= '0;
            ki_q        <= '0;
            kj_q        <= '0;
            mac_en_q    <= 1'b0;
            mac_clear_q <= 1'b0;
            wlast_q     <= 1'b0;
            fin1_q      <= 1'b0;
            row1_q      <= '0;
            col1_q      <= '0;
            out_we_q    <= 1'b0;
            fin2_q      <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_r_q     <= out_r_d;
            out_c_q     <= out_c_d;
            ki_q        <= ki_d;
            kj_q        <= kj_d;
            mac_en_q    <= mac_en_d;
            mac_clear_q <= mac_clear_d;
            wlast_q     <= wlast_d;
            fin1_q      <= fin1_d;
            row1_q      <= row1_d;
            col1_q      <= col1_d;
            out_we_q    <= out_we_d;
            fin2_q      <= fin2_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    always_comb begin
        busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        rd_valid  = issue;
        mac_en    = mac_en_q;
        mac_clear = mac_clear_q;
        out_we    = out_we_q;
        out_row   = out_row_q;
        out_col   = out_col_q;
        img_row   = '0;
        img_col   = '0;
        ker_row   = '0;
        ker_col   = '0;
        // Addresses only leave the block while windows are being walked
        if (state_q == S_RUN) begin
            img_row = AW'({1'b0, out_r_q} * STR + {1'b0, ki_q});
            img_col = AW'({1'b0, out_c_q} * STR + {1'b0, kj_q});
            ker_row = ki_q;
            ker_col = kj_q;
        end
    end

endmodule

// File: doc/conv2_scheduler.md
Name: conv2_scheduler

Overview:
Sequencer for a single-MAC 2D valid-convolution engine that replaces the fully unrolled conv2 array. It walks every output window and every kernel tap, issuing image and kernel read addresses. It drives MAC clear/enable and output write-back, and raises done when the full output map has been written. It sits between the image/kernel memories and the shared MAC accumulator in the conv2 datapath.

Parameters:
SIZE, 32, image height/width in pixels (square)
SIZEKer, 3, kernel height/width (square); must satisfy 1 <= SIZEKer <= SIZE
STRIDE, 1, window step in rows and columns; (SIZE-SIZEKer) must be divisible by STRIDE
AW, $clog2(SIZE), width of row/column address fields (minimum 1)

Ports:
clock  in  1  rising-edge clock
nreset  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a full convolution; honoured only in IDLE or DONE
stall  in  1  high = memories not ready; freezes address issue in the current cycle
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE; held until the next accepted start
img_row  out  AW  image read row = out_r*STRIDE + ki
img_col  out  AW  image read column = out_c*STRIDE + kj
ker_row  out  AW  kernel read row ki
ker_col  out  AW  kernel read column kj
rd_valid  out  1  addresses above are issued this cycle
mac_clear  out  1  with mac_en: load product into the accumulator instead of adding it
mac_en  out  1  read data valid this cycle; MAC consumes it
out_we  out  1  accumulator holds a finished window; write it back
out_row  out  AW  output row index for out_we
out_col  out  AW  output column index for out_we

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low on nreset, named nreset as throughout the codebase. While reset is asserted: state=IDLE, all counters=0, every output=0.
- Definitions: NOUT=(SIZE-SIZEKer)/STRIDE+1 and TAPS=SIZEKer*SIZEKer.
- Counters: out_r, out_c, ki, kj. On each issue, kj increments first. When kj wraps, ki increments. When ki wraps, out_c increments. When out_c wraps, out_r increments.
- States:
  - IDLE: outputs 0. start -> RUN, with counters cleared.
  - RUN: rd_valid=~stall. When stall=1, counters hold and no address is issued. Issuing the tap with out_r=out_c=NOUT-1, ki=kj=SIZEKer-1 -> DRAIN.
  - DRAIN: rd_valid=0. Wait until the final out_we has been asserted -> DONE.
  - DONE: done=1. start -> RUN with counters cleared and done dropping the same edge. Otherwise hold.
- Start handling: start in RUN or DRAIN is ignored.
- Pipeline timing, fixed: memory read latency is 1 cycle.
  - mac_en(t+1)=rd_valid(t).
  - mac_clear(t+1)=rd_valid(t) & (ki==0 & kj==0 at t).
  - out_we(t+2) is asserted when the tap issued at t was the last tap of its window (ki=kj=SIZEKer-1).
  - out_row/out_col are pipelined alongside and valid only when out_we=1; otherwise they hold their last value.
- Stall inserts bubbles: mac_en=0 in the following cycle. Stall never drops or duplicates a tap.
- Throughput: with no stall, one tap per cycle, back-to-back windows, no gap cycles. First out_we occurs TAPS+1 cycles after the first rd_valid. Total from start to done = NOUT*NOUT*TAPS + 3 cycles.
- Address widths: img_row/img_col never exceed SIZE-1. Arithmetic is computed at AW+1 bits and truncated; no wrap is possible given the parameter constraints.
- Stall in DRAIN has no effect; the pipeline still empties.
- Reset mid-operation: immediate return to IDLE. No out_we is produced after reset release until a new start.
- SIZEKer==SIZE: NOUT=1, one window. SIZEKer==1: mac_clear=mac_en on every tap, out_we every cycle.

Test Plan:
- SIZE=4, SIZEKer=3, STRIDE=1, no stall, start pulse -> 36 rd_valid cycles; 4 out_we pulses at (0,0),(0,1),(1,0),(1,1); first out_we 10 cycles after first rd_valid; done 39 cycles after start. Golden-model MAC output matches a software conv of an incrementing image with an all-ones kernel.
- Same config, stall asserted every 3rd cycle in RUN -> same 36 unique address tuples in the same order, mac_en count=36, identical output values, done delayed by the number of stalled cycles.
- SIZE=5, SIZEKer=3, STRIDE=2 -> NOUT=2. Window origins are (0,0),(0,2),(2,0),(2,2); max img_row/img_col = 4.
- nreset pulled low mid-RUN after 20 taps -> all outputs 0 immediately; no out_we after release. A new start yields a full correct run.
- start asserted during RUN, and again in DONE -> the RUN start is ignored (tap order unchanged); the DONE start drops done and reruns.
- SIZE=32, SIZEKer=3 default -> 900 out_we pulses, row-major order; done after 8103 cycles.
